// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed scan controller for common-anode 7-segment digits.
// One shared decoder is stepped through the digits; segments and anodes are registered.
//
// state | meaning
// IDLE  | display dark, index/prescaler held at zero, waiting for en
// SCAN  | stepping through digit slots, ghost interval at the start of each slot
module seg7_scan_ctrl #(
   parameter int NUM_DIGITS  = 4,
   parameter int CNT_W       = 16,
   parameter int REFRESH_DIV = 50000,
   parameter int GHOST_CYC   = 2
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    en,
   input  logic                    load,
   input  logic [4*NUM_DIGITS-1:0] digits_in,
   input  logic                    blank_lz,
   output logic [3:0]              dec_m,
   input  logic [6:0]              dec_seg,
   output logic [6:0]              seg,
   output logic [NUM_DIGITS-1:0]   an,
   output logic                    frame_done
);

   localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam logic [CNT_W-1:0] PRESC_TC = CNT_W'(REFRESH_DIV - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
   localparam logic [6:0]       SEG_OFF  = 7'b1111111;

   typedef enum logic {IDLE, SCAN} state_t;

   state_t                  state;
   logic [IDX_W-1:0]        idx;
   logic [CNT_W-1:0]        presc;
   logic [4*NUM_DIGITS-1:0] active;
   logic [4*NUM_DIGITS-1:0] shadow;
   logic                    pending;

   logic                    tc;
   logic                    wrap;
   logic                    entry;
   logic                    xfer;
   logic                    ghost;
   logic                    lz_hit;
   logic                    blanked;
   logic                    run_zero;
   logic [NUM_DIGITS-1:0]   zero_above;
   logic [NUM_DIGITS-1:0]   an_dec;

   generate
      if (GHOST_CYC > 0) begin : g_ghost
         localparam logic [CNT_W-1:0] GHOST_LIM = CNT_W'(GHOST_CYC);
         assign ghost = (presc < GHOST_LIM);
      end else begin : g_no_ghost
         assign ghost = 1'b0;
      end
   endgenerate

   always_comb begin
      dec_m  = 4'd0;
      an_dec = '1;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (idx == IDX_W'(i)) begin
            dec_m     = active[4*i +: 4];
            an_dec[i] = 1'b0;
         end
      end
   end

   // zero_above[i]: digits i..NUM_DIGITS-1 of the active value are all zero
   always_comb begin
      run_zero   = 1'b1;
      zero_above = '0;
      for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
         run_zero      = run_zero & (active[4*i +: 4] == 4'd0);
         zero_above[i] = run_zero;
      end
   end

   always_comb begin
      lz_hit = 1'b0;
      for (int i = 1; i < NUM_DIGITS; i++) begin
         if (idx == IDX_W'(i)) lz_hit = zero_above[i];
      end
   end

   assign blanked = ghost | (state == IDLE) | (blank_lz & lz_hit);
   assign tc      = (presc == PRESC_TC);
   assign wrap    = (state == SCAN) & en & tc & (idx == IDX_LAST);
   assign entry   = (state == IDLE) & en;
   assign xfer    = wrap | entry;

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         idx        <= '0;
         presc      <= '0;
         active     <= '0;
         shadow     <= '0;
         pending    <= 1'b0;
         seg        <= SEG_OFF;
         an         <= '1;
         frame_done <= 1'b0;
      end else begin
         frame_done <= wrap;

         if (load) begin
            shadow  <= digits_in;
            pending <= 1'b1;
         end
         // A load coinciding with the transfer point goes straight to active.
         if (xfer) begin
            if (load)         active <= digits_in;
            else if (pending) active <= shadow;
            pending <= 1'b0;
         end

         case (state)
            IDLE: begin
               seg   <= SEG_OFF;
               an    <= '1;
               idx   <= '0;
               presc <= '0;
               if (en) state <= SCAN;
            end
            SCAN: begin
               if (!en) begin
                  state <= IDLE;
                  seg   <= SEG_OFF;
                  an    <= '1;
                  idx   <= '0;
                  presc <= '0;
               end else begin
                  seg <= blanked ? SEG_OFF : dec_seg;
                  an  <= blanked ? '1 : an_dec;
                  if (tc) begin
                     presc <= '0;
                     idx   <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
                  end else begin
                     presc <= presc + 1'b1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench for seg7_scan_ctrl with a real active-low hex decoder attached.
// Four digits, four cycles per slot, one ghost cycle per slot.
module tb_seg7_scan_ctrl;

   localparam logic [6:0] S0   = 7'b1000000;
   localparam logic [6:0] S1   = 7'b1111001;
   localparam logic [6:0] S2   = 7'b0100100;
   localparam logic [6:0] S3   = 7'b0110000;
   localparam logic [6:0] S4   = 7'b0011001;
   localparam logic [6:0] S5   = 7'b0010010;
   localparam logic [6:0] S6   = 7'b0000010;
   localparam logic [6:0] S7   = 7'b1111000;
   localparam logic [6:0] S8   = 7'b0000000;
   localparam logic [6:0] S9   = 7'b0010000;
   localparam logic [6:0] SOFF = 7'b1111111;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        en = 1'b1;
   logic        load = 1'b1;
   logic [15:0] digits_in = 16'hFFFF;
   logic        blank_lz = 1'b0;
   logic [3:0]  dec_m;
   logic [6:0]  dec_seg;
   logic [6:0]  seg;
   logic [3:0]  an;
   logic        frame_done;

   int checks = 0;
   int errors = 0;

   seg7_scan_ctrl #(
      .NUM_DIGITS (4),
      .CNT_W      (4),
      .REFRESH_DIV(4),
      .GHOST_CYC  (1)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .load      (load),
      .digits_in (digits_in),
      .blank_lz  (blank_lz),
      .dec_m     (dec_m),
      .dec_seg   (dec_seg),
      .seg       (seg),
      .an        (an),
      .frame_done(frame_done)
   );

   always #5 clk = ~clk;

   always_comb begin
      case (dec_m)
         4'd0:    dec_seg = S0;
         4'd1:    dec_seg = S1;
         4'd2:    dec_seg = S2;
         4'd3:    dec_seg = S3;
         4'd4:    dec_seg = S4;
         4'd5:    dec_seg = S5;
         4'd6:    dec_seg = S6;
         4'd7:    dec_seg = S7;
         4'd8:    dec_seg = S8;
         4'd9:    dec_seg = S9;
         default: dec_seg = SOFF;
      endcase
   end

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_dark(input string tag);
      check_val({tag, " an"}, 32'(an), 32'hF);
      check_val({tag, " seg"}, 32'(seg), 32'(SOFF));
      check_val({tag, " fd"}, 32'(frame_done), 32'd0);
   endtask

   // One digit slot: ghost cycle then three lit cycles; optional load pulse on the ghost edge.
   task automatic do_slot(input string tag, input int d, input logic lit, input logic [6:0] s,
                          input logic ld, input logic [15:0] v);
      logic [3:0] an_e;
      logic [6:0] seg_e;
      an_e  = lit ? ~(4'b0001 << d) : 4'hF;
      seg_e = lit ? s : SOFF;
      if (ld) begin
         load      = 1'b1;
         digits_in = v;
      end
      step();
      load = 1'b0;
      check_dark($sformatf("%s d%0d ghost", tag, d));
      for (int k = 0; k < 3; k++) begin
         step();
         check_val($sformatf("%s d%0d an c%0d", tag, d, k), 32'(an), 32'(an_e));
         check_val($sformatf("%s d%0d seg c%0d", tag, d, k), 32'(seg), 32'(seg_e));
         check_val($sformatf("%s d%0d fd c%0d", tag, d, k), 32'(frame_done),
                   32'((d == 3) && (k == 2)));
      end
   endtask

   task automatic frame(input string tag, input logic [6:0] s3, input logic [6:0] s2,
                        input logic [6:0] s1, input logic [6:0] s0, input logic [3:0] m,
                        input int la, input logic [15:0] va, input int lb, input logic [15:0] vb);
      logic [6:0] s[4];
      s = '{s0, s1, s2, s3};
      for (int d = 0; d < 4; d++) begin
         if (la == d)      do_slot(tag, d, m[d], s[d], 1'b1, va);
         else if (lb == d) do_slot(tag, d, m[d], s[d], 1'b1, vb);
         else              do_slot(tag, d, m[d], s[d], 1'b0, 16'h0);
      end
   endtask

   initial begin
      for (int i = 0; i < 3; i++) begin
         step();
         check_dark($sformatf("reset c%0d", i));
      end
      rst  = 1'b0;
      load = 1'b0;
      en   = 1'b0;
      step();
      check_dark("idle");
      en = 1'b1;
      step();
      check_dark("entry");

      // active must be zero despite the load held during reset; 1234 loaded mid-frame
      frame("zero", S0, S0, S0, S0, 4'hF, 0, 16'h1234, -1, 16'h0);
      frame("1234", S1, S2, S3, S4, 4'hF, 1, 16'h5678, -1, 16'h0);
      frame("5678", S5, S6, S7, S8, 4'hF, 0, 16'h9999, 2, 16'h0070);
      frame("0070 nolz", S0, S0, S7, S0, 4'hF, -1, 16'h0, -1, 16'h0);
      blank_lz = 1'b1;
      frame("0070 lz", S0, S0, S7, S0, 4'b0011, 1, 16'h0000, -1, 16'h0);
      frame("0000 lz", S0, S0, S0, S0, 4'b0001, -1, 16'h0, -1, 16'h0);
      blank_lz = 1'b0;
      frame("0000 nolz", S0, S0, S0, S0, 4'hF, 1, 16'h00A9, -1, 16'h0);
      frame("00A9", S0, S0, SOFF, S9, 4'hF, 0, 16'h1234, -1, 16'h0);

      do_slot("drop", 0, 1'b1, S4, 1'b0, 16'h0);
      do_slot("drop", 1, 1'b1, S3, 1'b0, 16'h0);
      step();
      check_dark("drop d2 ghost");
      step();
      check_val("drop d2 an", 32'(an), 32'hB);
      check_val("drop d2 seg", 32'(seg), 32'(S2));
      en = 1'b0;
      step();
      check_dark("drop off");
      load      = 1'b1;
      digits_in = 16'h4321;
      step();
      load = 1'b0;
      step();
      check_dark("drop idle");
      en = 1'b1;
      step();
      check_dark("drop reentry");
      frame("4321", S4, S3, S2, S1, 4'hF, -1, 16'h0, -1, 16'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/seg7_scan_ctrl.md
Name: seg7_scan_ctrl

Overview:
- Time-multiplexed scan controller for a bank of common-anode 7-segment digits sharing one 4-bit→7-segment decoder instance.
- Holds a packed BCD value, steps the shared decoder input through each digit, and registers the decoder's active-low segment output together with the matching active-low digit enable.
- Provides load double-buffering, leading-zero blanking, an anti-ghosting blank interval and a frame-done strobe.
- Sits between the arithmetic/BCD datapath and the board display pins.

Parameters:
- NUM_DIGITS, 4, number of digits scanned (≥1).
- CNT_W, 16, prescaler width; must hold REFRESH_DIV-1.
- REFRESH_DIV, 50000, clk cycles per digit slot (≥1).
- GHOST_CYC, 2, cycles at the start of each slot with all digits off; 0 disables; must be < REFRESH_DIV.

Ports:
- clk, input, 1, system clock; all state on rising edge.
- rst, input, 1, synchronous active-high reset.
- en, input, 1, scan enable; low = display dark.
- load, input, 1, single-cycle strobe capturing digits_in.
- digits_in, input, 4*NUM_DIGITS, packed BCD; nibble i = digit i; digit 0 is least significant.
- blank_lz, input, 1, leading-zero blanking enable (sampled live).
- dec_m, output, 4, nibble driven to the shared decoder.
- dec_seg, input, 7, decoder output (active low; codes 10-15 return 7'b1111111).
- seg, output, 7, registered segment drive, active low.
- an, output, NUM_DIGITS, registered digit enables, active low; bit i = digit i.
- frame_done, output, 1, one-cycle pulse when the digit index wraps NUM_DIGITS-1→0.

Behaviour:
- Reset: idx=0, presc=0, active=0, shadow=0, pending=0, state=IDLE, an=all 1, seg=7'b1111111, frame_done=0.
- States: IDLE, SCAN.
  - IDLE→SCAN when en=1. On the entry cycle: idx=0, presc=0, and active←shadow if pending.
  - SCAN→IDLE when en=0. Next edge: an=all 1, seg=7F, idx=0, presc=0.
- SCAN timing:
  - presc counts 0..REFRESH_DIV-1.
  - At terminal count: presc←0; idx←idx+1, wrapping NUM_DIGITS-1→0.
  - On wrap: frame_done=1 for one cycle; if pending, active←shadow and pending←0.
- Load:
  - load=1 in any state: shadow←digits_in, pending←1. Last load before the transfer point wins.
  - A load in the same cycle as a wrap or SCAN entry transfers digits_in directly to active.
  - Active never changes mid-frame, so no tearing.
- dec_m = active nibble[idx] (combinational from registers).
- Output registration, one cycle after idx/presc:
  - seg ← blanked ? 7'b1111111 : dec_seg.
  - an ← blanked ? all 1 : ~(1<<idx).
- blanked (any of):
  - presc < GHOST_CYC;
  - state=IDLE;
  - blank_lz=1 and idx>0 and active digits idx..NUM_DIGITS-1 are all 0.
  - Digit 0 is never lz-blanked.
- Invalid BCD (A-F): passed to the decoder unchanged; the decoder blanks it. an still enables that digit.
- REFRESH_DIV=1 with GHOST_CYC=0: advance every cycle. frame_done fires every NUM_DIGITS cycles.
- rst dominates en and load in the same cycle.

Test Plan (NUM_DIGITS=4, REFRESH_DIV=4, GHOST_CYC=1, real decoder attached):
- Reset: rst=1 for 3 cycles, en=1, load=1 → an=4'b1111, seg=7'b1111111, frame_done=0 throughout; after release with load=0, active=0.
- Basic scan: load 16'h1234, en=1 → slot 0: an=1110, seg=7'b0011001 for 3 cycles after 1 ghost cycle. Then 1101/0110000, 1011/0100100, 0111/1111001. frame_done pulses every 16 cycles.
- Leading zero: blank_lz=1, value 16'h0070 → digits 3,2 an=1111; digit1 seg=7'b1111000; digit0 seg=7'b1000000. Value 16'h0000 → only digit0 lit with 7'b1000000. Same values with blank_lz=0 → all four lit.
- Double-buffer: showing 16'h1234, load 16'h5678 during the digit-1 slot → digits 2,3 still show 2,1. From the next digit-0 slot: 8,7,6,5. Two loads in one frame → only the last is displayed.
- Invalid code: load 16'h00A9, blank_lz=0 → digit1 an=1101 with seg=7'b1111111; digit0 seg=7'b0010000.
- Enable drop: en=0 during the digit-2 slot → next edge an=1111, seg=7F. Re-assert en → scan restarts at digit 0 with a full ghost+3-cycle slot. A load made while disabled is shown from the first slot.
